// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32M definitions for the EX-stage multiply/divide sequencer.
//   - funct3 encodings for the M-extension operations
//   - funct7 value identifying an M-extension instruction
//   - muldiv_state_t: sequencer FSM states
//   - helpers returning which operands are treated as signed for a funct3
package riscv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } muldiv_state_t;

    // rs1 is signed for MULH, MULHSU, DIV and REM.
    // MUL's low word is identical either way.
    function automatic logic f3_a_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is signed for MULH, DIV and REM.
    function automatic logic f3_b_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: datapath of the iterative multiply/divide unit.
// It works on operand magnitudes and applies the result sign at the end.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            capture funct3, operand magnitudes and sign flags
//   step            perform one shift-add (multiply) or restoring step (divide)
//   funct3          live operation select (sampled on load)
//   op_a, op_b      live operands (sampled on load)
//   special         live operands form a divide-by-zero or signed-overflow case
//   special_result  architectural result for that special case
//   fix_result      sign-corrected, selected result of the latched operation
module muldiv_core
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            special,
    output logic [XLEN-1:0] special_result,
    output logic [XLEN-1:0] fix_result
);

    logic [2:0]        f3_r;
    logic [2*XLEN-1:0] acc_r;      // multiply: {high, multiplier/low}; divide: low half is dividend/quotient
    logic [XLEN-1:0]   mcand_r;    // multiplicand or divisor magnitude
    logic [XLEN-1:0]   rem_r;      // partial remainder; always below the divisor between steps
    logic              neg_r;      // product/quotient must be negated
    logic              rem_neg_r;  // remainder must be negated (dividend negative)

    logic              a_neg_s;
    logic              b_neg_s;
    logic [XLEN-1:0]   mag_a_s;
    logic [XLEN-1:0]   mag_b_s;
    logic              div_zero_s;
    logic              div_ovf_s;

    logic [XLEN:0]     mul_sum_s;
    logic [XLEN:0]     div_shift_s;  // 33-bit partial remainder under comparison
    logic              div_ge_s;
    logic [XLEN-1:0]   div_diff_s;
    logic [2*XLEN-1:0] acc_nxt_s;
    logic [XLEN-1:0]   rem_nxt_s;

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s;
    logic [XLEN-1:0]   remv_s;

    // Operand magnitudes, sign flags and special-case detection from the live inputs.
    always_comb begin
        a_neg_s    = f3_a_signed(funct3) & op_a[XLEN-1];
        b_neg_s    = f3_b_signed(funct3) & op_b[XLEN-1];
        mag_a_s    = a_neg_s ? ({XLEN{1'b0}} - op_a) : op_a;
        mag_b_s    = b_neg_s ? ({XLEN{1'b0}} - op_b) : op_b;
        div_zero_s = funct3[2] & (op_b == {XLEN{1'b0}});
        div_ovf_s  = funct3[2] & f3_b_signed(funct3)
                   & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == {XLEN{1'b1}});
        special    = div_zero_s | div_ovf_s;
        // funct3[1] distinguishes REM/REMU from DIV/DIVU
        if (div_zero_s) begin
            special_result = funct3[1] ? op_a : {XLEN{1'b1}};
        end else begin
            special_result = funct3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // One iteration: shift-add for multiply, restore-or-subtract for divide.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, mcand_r} : {(XLEN+1){1'b0}});
        div_shift_s = {rem_r, acc_r[XLEN-1]};
        div_ge_s    = (div_shift_s >= {1'b0, mcand_r});
        // Only taken when div_shift_s >= divisor, so the difference fits XLEN bits.
        div_diff_s  = div_shift_s[XLEN-1:0] - mcand_r;
        if (f3_r[2]) begin
            acc_nxt_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-2:0], div_ge_s};
            rem_nxt_s = div_ge_s ? div_diff_s : div_shift_s[XLEN-1:0];
        end else begin
            acc_nxt_s = {mul_sum_s, acc_r[XLEN-1:1]};
            rem_nxt_s = rem_r;
        end
    end

    // Datapath registers: capture on load, advance on step.
    always_ff @(posedge clk) begin
        if (rst) begin
            f3_r      <= 3'd0;
            acc_r     <= {(2*XLEN){1'b0}};
            mcand_r   <= {XLEN{1'b0}};
            rem_r     <= {XLEN{1'b0}};
            neg_r     <= 1'b0;
            rem_neg_r <= 1'b0;
        end else if (load) begin
            f3_r      <= funct3;
            acc_r     <= {{XLEN{1'b0}}, mag_a_s};
            mcand_r   <= mag_b_s;
            rem_r     <= {XLEN{1'b0}};
            neg_r     <= a_neg_s ^ b_neg_s;
            rem_neg_r <= a_neg_s;
        end else if (step) begin
            acc_r     <= acc_nxt_s;
            rem_r     <= rem_nxt_s;
        end
    end

    // Sign correction and result selection for the FIX state.
    always_comb begin
        prod_s = neg_r ? ({(2*XLEN){1'b0}} - acc_r) : acc_r;
        quot_s = neg_r ? ({XLEN{1'b0}} - acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];
        remv_s = rem_neg_r ? ({XLEN{1'b0}} - rem_r) : rem_r;
        case (f3_r)
            F3_MUL:                       fix_result = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_result = quot_s;
            default:                      fix_result = remv_s;
        endcase
    end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// ex_muldiv_sequencer: RV32M multi-cycle multiply/divide sequencer for the EX stage.
// Holds the pipeline stalled while an M-extension op runs, then pulses done with
// a registered result. A flush cancels any in-flight operation.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       EX holds a valid M-extension instruction (held until done)
//   funct3      operation select
//   op_a, op_b  forwarded rs1/rs2 values
//   flush       kill any in-flight operation
//   busy        FSM not in IDLE
//   stall       freeze IF/ID/EX (start & ~done & ~flush)
//   done        one-cycle result-valid pulse
//   result      registered result, held until the next accepted start
module ex_muldiv_sequencer
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    muldiv_state_t   state_r;
    logic [5:0]      cnt_r;
    logic            busy_r;
    logic            done_r;
    logic [XLEN-1:0] result_r;

    logic            accept_s;
    logic            step_s;
    logic            special_s;
    logic [XLEN-1:0] special_result_s;
    logic [XLEN-1:0] fix_result_s;

    // Core control: load on acceptance, iterate while in MUL or DIV.
    always_comb begin
        accept_s = (state_r == IDLE) & start & ~flush;
        step_s   = (state_r == MUL) | (state_r == DIV);
    end

    muldiv_core #(
        .XLEN(XLEN)
    ) u_core (
        .clk            (clk),
        .rst            (rst),
        .load           (accept_s),
        .step           (step_s),
        .funct3         (funct3),
        .op_a           (op_a),
        .op_b           (op_b),
        .special        (special_s),
        .special_result (special_result_s),
        .fix_result     (fix_result_s)
    );

    // Sequencer FSM with iteration counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= 6'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {XLEN{1'b0}};
        end else if (flush) begin
            // Cancel: result is left untouched, no done pulse follows.
            state_r  <= IDLE;
            cnt_r    <= 6'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    cnt_r  <= 6'd0;
                    if (start) begin
                        busy_r <= 1'b1;
                        if (special_s) begin
                            result_r <= special_result_s;
                            done_r   <= 1'b1;
                            state_r  <= DONE;
                        end else if (funct3[2]) begin
                            state_r  <= DIV;
                        end else begin
                            state_r  <= MUL;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                MUL, DIV: begin
                    cnt_r <= cnt_r + 6'd1;
                    if (cnt_r == 6'd31) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= state_r;
                    end
                end
                FIX: begin
                    result_r <= fix_result_s;
                    done_r   <= 1'b1;
                    state_r  <= DONE;
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign stall  = start & ~done_r & ~flush;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
module tb_ex_muldiv_sequencer;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int          err_cnt = 0;
    int          chk_cnt = 0;
    logic [31:0] last_res;

    ex_muldiv_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Architectural RV32M result computed with wide integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ax;
        logic [63:0] bx;
        logic [63:0] p;
        int          ia;
        int          ib;
        ax = ((f3 == F3_MULH) || (f3 == F3_MULHSU)) ? {{32{a[31]}}, a} : {32'd0, a};
        bx = (f3 == F3_MULH) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ax * bx;
        ia = a;
        ib = b;
        if (f3 == F3_MUL) return p[31:0];
        if (f3 == F3_MULH || f3 == F3_MULHSU || f3 == F3_MULHU) return p[63:32];
        if (b == 32'd0) return f3[1] ? a : 32'hFFFFFFFF;
        if (f3 == F3_DIV || f3 == F3_REM) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return f3[1] ? 32'd0 : 32'h80000000;
            if (f3 == F3_DIV) return ia / ib;
            return ia % ib;
        end
        if (f3 == F3_DIVU) return a / b;
        return a % b;
    endfunction

    // Cycle of done relative to acceptance: 1 for the short-circuit cases, else 34.
    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3 >= F3_DIV && b == 32'd0) return 1;
        if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 34;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int          k;
        int          stall_n;
        logic        seen;
        logic [31:0] exp_r;
        int          exp_k;
        exp_r = ref_result(f3, a, b);
        exp_k = ref_latency(f3, a, b);
        @(negedge clk);
        check_eq({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_idle_done"}, {31'd0, done}, 32'd0);
        check_eq({tag, "_held_result"}, result, last_res);
        start = 1'b1; funct3 = f3; op_a = a; op_b = b;
        #1;
        stall_n = stall ? 1 : 0;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 100) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check_eq({tag, "_busy_c1"}, {31'd0, busy}, 32'd1);
                // Operand changes after acceptance must have no effect.
                op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
            end
            if (stall) stall_n++;
            if (done) seen = 1'b1;
        end
        check_eq({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check_eq({tag, "_latency"}, k, exp_k);
        check_eq({tag, "_stall_cycles"}, stall_n, exp_k);
        check_eq({tag, "_result"}, result, exp_r);
        start = 1'b0;
        last_res = exp_r;
    endtask

    initial begin
        logic        seen;
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b1; start = 1'b1; flush = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
        last_res = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_stall_hi", {31'd0, stall}, 32'd1);
        start = 1'b0;
        #1;
        check_eq("rst_stall_lo", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mul7", F3_MUL, 32'd7, 32'hFFFFFFFD);
        run_op("mulhu", F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("mulh", F3_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("mulhsu", F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("div_neg", F3_DIV, 32'hFFFFFFF9, 32'd2);
        run_op("rem_neg", F3_REM, 32'hFFFFFFF9, 32'd2);
        run_op("divu", F3_DIVU, 32'd100, 32'd7);
        run_op("remu", F3_REMU, 32'd100, 32'd7);
        run_op("divu_z", F3_DIVU, 32'd5, 32'd0);
        run_op("rem_z", F3_REM, 32'd5, 32'd0);
        run_op("div_ovf", F3_DIV, 32'h80000000, 32'hFFFFFFFF);
        run_op("rem_ovf", F3_REM, 32'h80000000, 32'hFFFFFFFF);
        run_op("b2b_mul", F3_MUL, 32'd3, 32'd4);
        run_op("b2b_div", F3_DIV, 32'd12, 32'd4);

        // Flush at iteration 10 of a multiply.
        @(negedge clk);
        start = 1'b1; funct3 = F3_MUL; op_a = 32'h12345678; op_b = 32'h9ABCDEF0;
        repeat (11) @(negedge clk);
        flush = 1'b1;
        #1;
        check_eq("flush_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check_eq("flush_busy", {31'd0, busy}, 32'd0);
        check_eq("flush_done", {31'd0, done}, 32'd0);
        check_eq("flush_result", result, last_res);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check_eq("flush_no_done", {31'd0, seen}, 32'd0);

        // Flush together with start in IDLE: not accepted.
        start = 1'b1; flush = 1'b1; funct3 = F3_DIVU; op_a = 32'd9; op_b = 32'd0;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check_eq("flush_idle_busy", {31'd0, busy}, 32'd0);
        check_eq("flush_idle_done", {31'd0, done}, 32'd0);

        // Reset in the middle of a divide.
        run_op("pre_rst", F3_MULHU, 32'hDEADBEEF, 32'h01234567);
        @(negedge clk);
        start = 1'b1; funct3 = F3_DIV; op_a = 32'd1000; op_b = 32'd7;
        repeat (15) @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_done", {31'd0, done}, 32'd0);
        check_eq("midrst_result", result, 32'd0);
        last_res = 32'd0;

        // Randomized operations, biased toward signed/zero boundary operands.
        for (int i = 0; i < 40; i++) begin
            rf3 = 3'($urandom);
            case ($urandom_range(0, 3))
                0:       ra = 32'h80000000;
                1:       ra = $urandom_range(0, 20);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = $urandom_range(1, 9);
                default: rb = $urandom;
            endcase
            run_op($sformatf("rnd%0d_f%0d", i, rf3), rf3, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
